dma_request_arbiter: RTL and testbench

- Shares the accelerator's single DMA read/write channel between NUM_REQ tile requesters: A-tile loader, B-tile loader and C-tile writeback.
- Grants one requester at a time using round-robin arbitration.
- For each grant, issues one dma_start, counts per-beat dma_done, routes read beats back to the owner and muxes write data from it.
- Sits between the load/store sequencers and the DMA engine.

---
 rtl/dma_request_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dma_request_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_request_arbiter.sv
// Round-robin arbiter sharing one DMA read/write channel between NUM_REQ
// tile requesters (0 = A loader, 1 = B loader, 2 = C writeback).
// One grant at a time: latch the owner's command, pulse dma_start, count
// per-beat dma_done, pulse done to the owner, then return to IDLE.
module dma_request_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int DATA_W  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        beat_valid,
    output logic [NUM_REQ-1:0]        done,
    output logic                      dma_start,
    output logic [ADDR_W-1:0]         dma_addr,
    output logic [LEN_W-1:0]          dma_len,
    output logic                      dma_write,
    output logic [DATA_W-1:0]         dma_wdata,
    input  logic                      dma_done,
    output logic                      busy,
    output logic                      err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [LEN_W-1:0]    beat_cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                dma_start_q;
    logic [ADDR_W-1:0]   dma_addr_q;
    logic [LEN_W-1:0]    dma_len_q;
    logic                dma_write_q;
    logic                busy_q;
    logic                err_q;

    logic                sel_found_s;
    logic [PTR_W-1:0]    sel_idx_s;
    logic [NUM_REQ-1:0]  sel_onehot_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [LEN_W-1:0]    sel_len_s;
    logic                sel_write_s;
    logic                last_beat_s;

    // Round-robin search: first pending request starting at rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!sel_found_s && req[idx_v]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = PTR_W'(idx_v);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Command fields of the selected requester.
    always_comb begin
        sel_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
        sel_addr_s   = req_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
        sel_len_s    = req_len[int'(sel_idx_s)*LEN_W +: LEN_W];
        sel_write_s  = req_write[sel_idx_s];
        last_beat_s  = (beat_cnt_q == (dma_len_q - LEN_W'(1'b1)));
    end

    // Write-data mux: OR of owner-qualified slices; zero while no grant is held.
    always_comb begin
        dma_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dma_wdata = dma_wdata | ({DATA_W{gnt_q[i]}} & req_wdata[i*DATA_W +: DATA_W]);
        end
    end

    // Beat strobe to the owner; only beats seen while transferring count.
    always_comb begin
        if (dma_done && (state_q == ST_XFER)) begin
            beat_valid = gnt_q;
        end else begin
            beat_valid = '0;
        end
    end

    // Control FSM with registered grant, command and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            dma_start_q <= 1'b0;
            dma_addr_q  <= '0;
            dma_len_q   <= '0;
            dma_write_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dma_start_q <= 1'b0;
            done_q      <= '0;
            if (dma_done && (state_q != ST_XFER)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_s) begin
                        gnt_q       <= sel_onehot_s;
                        dma_addr_q  <= sel_addr_s;
                        dma_len_q   <= sel_len_s;
                        dma_write_q <= sel_write_s;
                        beat_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        if (int'(sel_idx_s) == NUM_REQ - 1) begin
                            rr_ptr_q <= '0;
                        end else begin
                            rr_ptr_q <= sel_idx_s + PTR_W'(1'b1);
                        end
                        if (sel_len_s != '0) begin
                            dma_start_q <= 1'b1;
                            state_q     <= ST_XFER;
                        end else begin
                            done_q  <= sel_onehot_s;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_XFER: begin
                    if (dma_done) begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1'b1);
                        if (last_beat_s) begin
                            done_q  <= gnt_q;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign dma_start = dma_start_q;
    assign dma_addr  = dma_addr_q;
    assign dma_len   = dma_len_q;
    assign dma_write = dma_write_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed bench for dma_request_arbiter: reset, round-robin order, single
// read, zero length, gapped write mux, stray beat error, maximum length and
// asynchronous reset during a transfer.
module tb_dma_request_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 8;
    localparam int DATA_W  = 256;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        beat_valid;
    logic [NUM_REQ-1:0]        done;
    logic                      dma_start;
    logic [ADDR_W-1:0]         dma_addr;
    logic [LEN_W-1:0]          dma_len;
    logic                      dma_write;
    logic [DATA_W-1:0]         dma_wdata;
    logic                      dma_done;
    logic                      busy;
    logic                      err;

    int n_checks;
    int n_pass;
    int n_fail;

    dma_request_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_write(req_write), .req_wdata(req_wdata), .gnt(gnt),
        .beat_valid(beat_valid), .done(done), .dma_start(dma_start),
        .dma_addr(dma_addr), .dma_len(dma_len), .dma_write(dma_write),
        .dma_wdata(dma_wdata), .dma_done(dma_done), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0]   exp_g [4];
        logic [255:0] wd0, wd1, wd2;
        logic         gap_pat [7];
        int           beats;
        int           early_done;

        n_checks = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; req = '0; req_addr = '0; req_len = '0; req_write = '0;
        req_wdata = '0; dma_done = 1'b0;
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        gap_pat[0] = 1'b0; gap_pat[1] = 1'b1; gap_pat[2] = 1'b0; gap_pat[3] = 1'b1;
        gap_pat[4] = 1'b0; gap_pat[5] = 1'b0; gap_pat[6] = 1'b1;

        // ---- reset state
        #3;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", dma_start, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", dma_addr, 32'h0);
        next_cyc();
        rst = 1'b0;
        next_cyc();

        // ---- round robin: all three request, len 2 each, beat in start cycle
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 32'h2000 + 32'(i) * 32'h100;
            req_len[i*LEN_W +: LEN_W]    = 8'd2;
        end
        req = 3'b111;
        #1;
        chk("rr_idle_gnt", gnt, 3'b000);
        for (int g = 0; g < 4; g++) begin
            next_cyc();
            dma_done = 1'b1;
            if (g == 3) req = 3'b000;
            #1;
            chk("rr_gnt", gnt, exp_g[g]);
            chk("rr_start", dma_start, 1'b1);
            chk("rr_bv1", beat_valid, exp_g[g]);
            chk("rr_addr", dma_addr, (g == 1) ? 32'h2100 : (g == 2) ? 32'h2200 : 32'h2000);
            next_cyc();
            #1;
            chk("rr_start_low", dma_start, 1'b0);
            chk("rr_bv2", beat_valid, exp_g[g]);
            next_cyc();
            dma_done = 1'b0;
            #1;
            chk("rr_done", done, exp_g[g]);
            chk("rr_fin_gnt", gnt, exp_g[g]);
            next_cyc();
            #1;
            chk("rr_gap_gnt", gnt, 3'b000);
            chk("rr_gap_busy", busy, 1'b0);
            chk("rr_gap_start", dma_start, 1'b0);
        end

        // ---- single read from requester 0 (rr_ptr is now 1)
        next_cyc();
        req_addr[0 +: ADDR_W] = 32'h1000;
        req_len[0 +: LEN_W]   = 8'd4;
        req_write[0]          = 1'b0;
        req = 3'b001;
        #1;
        chk("sr_idle_start", dma_start, 1'b0);
        next_cyc();
        req = 3'b000;
        #1;
        chk("sr_start", dma_start, 1'b1);
        chk("sr_gnt", gnt, 3'b001);
        chk("sr_addr", dma_addr, 32'h1000);
        chk("sr_len", dma_len, 8'd4);
        chk("sr_write", dma_write, 1'b0);
        chk("sr_busy", busy, 1'b1);
        chk("sr_bv_none", beat_valid, 3'b000);
        for (int b = 0; b < 4; b++) begin
            next_cyc();
            dma_done = 1'b1;
            #1;
            chk("sr_bv", beat_valid, 3'b001);
            chk("sr_gnt_hold", gnt, 3'b001);
            chk("sr_no_done", done, 3'b000);
        end
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("sr_done", done, 3'b001);
        chk("sr_fin_busy", busy, 1'b1);
        next_cyc();
        #1;
        chk("sr_done_clr", done, 3'b000);
        chk("sr_busy_low", busy, 1'b0);
        chk("sr_gnt_low", gnt, 3'b000);

        // ---- zero length on requester 1
        req_len[1*LEN_W +: LEN_W] = 8'd0;
        req = 3'b010;
        next_cyc();
        req = 3'b000;
        #1;
        chk("zl_start", dma_start, 1'b0);
        chk("zl_gnt", gnt, 3'b010);
        chk("zl_done", done, 3'b010);
        chk("zl_busy", busy, 1'b1);
        next_cyc();
        #1;
        chk("zl_done_once", done, 3'b000);
        chk("zl_gnt_low", gnt, 3'b000);
        chk("zl_start_never", dma_start, 1'b0);
        chk("zl_err", err, 1'b0);

        // ---- write mux with gaps on requester 2
        wd0 = {8{32'hA0A0_0000}};
        wd1 = {8{32'hB1B1_1111}};
        wd2 = {8{32'hC2C2_2222}};
        req_wdata = {wd2, wd1, wd0};
        req_len[2*LEN_W +: LEN_W] = 8'd3;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h3000;
        req_write = 3'b100;
        req = 3'b100;
        #1;
        chk("wr_idle_wdata", dma_wdata, 256'h0);
        for (int c = 0; c < 7; c++) begin
            next_cyc();
            req = 3'b000;
            dma_done = gap_pat[c];
            #1;
            chk("wr_wdata", dma_wdata, wd2);
            chk("wr_bv", beat_valid, gap_pat[c] ? 3'b100 : 3'b000);
            chk("wr_dir", dma_write, 1'b1);
            chk("wr_start", dma_start, (c == 0) ? 1'b1 : 1'b0);
        end
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("wr_done", done, 3'b100);
        next_cyc();
        #1;
        chk("wr_idle_wdata2", dma_wdata, 256'h0);
        req_write = 3'b000;

        // ---- stray dma_done in IDLE
        dma_done = 1'b1;
        #1;
        chk("st_bv", beat_valid, 3'b000);
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("st_err", err, 1'b1);
        req_len[0 +: LEN_W] = 8'd1;
        req = 3'b001;
        next_cyc();
        req = 3'b000;
        dma_done = 1'b1;
        #1;
        chk("st_xfer_gnt", gnt, 3'b001);
        chk("st_xfer_bv", beat_valid, 3'b001);
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("st_xfer_done", done, 3'b001);
        chk("st_err_sticky", err, 1'b1);
        next_cyc();

        // ---- maximum length 255 on requester 1
        req_len[1*LEN_W +: LEN_W] = 8'd255;
        req = 3'b010;
        beats = 0;
        early_done = 0;
        for (int c = 0; c < 255; c++) begin
            next_cyc();
            req = 3'b000;
            dma_done = 1'b1;
            #1;
            if (beat_valid == 3'b010) beats++;
            if (done != 3'b000) early_done++;
        end
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("ml_beats", 256'(beats), 256'd255);
        chk("ml_early_done", 256'(early_done), 256'd0);
        chk("ml_done", done, 3'b010);
        next_cyc();

        // ---- async reset after beat 2 of 4 (requester 0)
        req_len[0 +: LEN_W] = 8'd4;
        req_len[1*LEN_W +: LEN_W] = 8'd2;
        req = 3'b001;
        next_cyc();
        req = 3'b000;
        #1;
        chk("ar_gnt", gnt, 3'b001);
        for (int b = 0; b < 2; b++) begin
            next_cyc();
            dma_done = 1'b1;
        end
        next_cyc();
        dma_done = 1'b0;
        req = 3'b010;
        rst = 1'b1;
        #1;
        chk("ar_gnt0", gnt, 3'b000);
        chk("ar_busy0", busy, 1'b0);
        chk("ar_addr0", dma_addr, 32'h0);
        chk("ar_len0", dma_len, 8'd0);
        chk("ar_err0", err, 1'b0);
        chk("ar_done0", done, 3'b000);
        next_cyc();
        #1;
        chk("ar_done_held", done, 3'b000);
        rst = 1'b0;
        next_cyc();
        req = 3'b000;
        #1;
        chk("ar_regnt", gnt, 3'b010);
        chk("ar_restart", dma_start, 1'b1);
        dma_done = 1'b1;
        next_cyc();
        next_cyc();
        dma_done = 1'b0;
        #1;
        chk("ar_redone", done, 3'b010);
        next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
